// File: rtl/noc_pkg.sv
// Shared NoC types and default widths for the core injection path.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } ci_state_t;

    localparam int FLIT_WIDTH_DEF      = 32;
    localparam int VC_PER_IN_PORTS_DEF = 2;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or above ptr_i (with wrap) wins.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/core_inject_arbiter.sv
// Shares one core_interface injection port among NUM_REQ requesters and
// sequences its READ (REn) then WRITE (WEn) handshake for each accepted flit.
//
// state | meaning
// IDLE  | arbitrate; pulse req_ready to the winner and latch its flit
// READ  | REn + v_from_core asserted with the latched flit
// WRITE | WEn asserted; router takes the flit next cycle
module core_inject_arbiter
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH      = FLIT_WIDTH_DEF,
    parameter int NUM_REQ         = 4,
    parameter int VC_PER_IN_PORTS = VC_PER_IN_PORTS_DEF,
    parameter int REQ_W           = $clog2(NUM_REQ),
    parameter int VC_W            = $clog2(VC_PER_IN_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ*VC_W-1:0]       req_vc,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [VC_PER_IN_PORTS-1:0]    vc_full,
    output logic                          ci_ren,
    output logic                          ci_wen,
    output logic                          ci_v,
    output logic [FLIT_WIDTH-1:0]         ci_flit,
    output logic [REQ_W-1:0]              grant_id,
    output logic                          busy
);

    ci_state_t             state_q;
    logic [REQ_W-1:0]      rr_ptr_q;
    logic [REQ_W-1:0]      rr_ptr_d;
    logic [REQ_W-1:0]      grant_id_q;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  ci_ren_q;
    logic                  ci_wen_q;
    logic                  ci_v_q;

    logic [NUM_REQ-1:0]    eligible;
    logic [VC_W-1:0]       vc_sel;
    logic [NUM_REQ-1:0]    win_oh;
    logic [REQ_W-1:0]      win_idx;
    logic                  win_any;
    logic [FLIT_WIDTH-1:0] win_flit;

    // Out-of-range VC indices never become eligible.
    always_comb begin
        eligible = '0;
        vc_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vc_sel = req_vc[i*VC_W +: VC_W];
            if (req_valid[i] && (int'(vc_sel) < VC_PER_IN_PORTS)) begin
                eligible[i] = ~vc_full[vc_sel];
            end
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (REQ_W)
    ) u_rr_arbiter (
        .req_i       (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (win_oh),
        .grant_idx_o (win_idx),
        .any_o       (win_any)
    );

    assign win_flit = req_flit[win_idx*FLIT_WIDTH +: FLIT_WIDTH];
    assign rr_ptr_d = (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            flit_q     <= '0;
            ci_ren_q   <= 1'b0;
            ci_wen_q   <= 1'b0;
            ci_v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        flit_q     <= win_flit;
                        grant_id_q <= win_idx;
                        rr_ptr_q   <= rr_ptr_d;
                        ci_ren_q   <= 1'b1;
                        ci_v_q     <= 1'b1;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    ci_ren_q <= 1'b0;
                    ci_v_q   <= 1'b0;
                    ci_wen_q <= 1'b1;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    ci_wen_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    ci_ren_q <= 1'b0;
                    ci_v_q   <= 1'b0;
                    ci_wen_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // The accept pulse is combinational so the requester can retire its flit this cycle.
    assign req_ready = (state_q == IDLE && !reset) ? win_oh : '0;

    assign ci_ren   = ci_ren_q;
    assign ci_wen   = ci_wen_q;
    assign ci_v     = ci_v_q;
    assign ci_flit  = flit_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_core_inject_arbiter.sv
// Bench for core_inject_arbiter: scoreboard of expected grants plus a cycle monitor.
module tb_core_inject_arbiter;

    localparam int FW = 32;
    localparam int NR = 4;
    localparam int NV = 2;
    localparam int RW = 2;
    localparam int VW = 1;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*FW-1:0] req_flit;
    logic [NR*VW-1:0] req_vc;
    logic [NR-1:0]    req_ready;
    logic [NV-1:0]    vc_full;
    logic             ci_ren;
    logic             ci_wen;
    logic             ci_v;
    logic [FW-1:0]    ci_flit;
    logic [RW-1:0]    grant_id;
    logic             busy;

    core_inject_arbiter #(
        .FLIT_WIDTH      (FW),
        .NUM_REQ         (NR),
        .VC_PER_IN_PORTS (NV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_flit  (req_flit),
        .req_vc    (req_vc),
        .req_ready (req_ready),
        .vc_full   (vc_full),
        .ci_ren    (ci_ren),
        .ci_wen    (ci_wen),
        .ci_v      (ci_v),
        .ci_flit   (ci_flit),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] flit;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    bit          chk_gap  = 1'b0;
    bit          have_last = 1'b0;
    int          last_gcyc = 0;
    logic        e_ren = 1'b0;
    logic        e_wen = 1'b0;
    logic [1:0]  e_id  = '0;
    logic [31:0] e_flit = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle monitor: interface outputs against the pipeline implied by observed accepts.
    always @(negedge clk) begin
        logic        n_ren;
        logic [1:0]  n_id;
        logic [31:0] n_flit;
        exp_t        ex;
        if (mon_en) begin
            chk("ci_ren", ci_ren, e_ren);
            chk("ci_v", ci_v, e_ren);
            chk("ci_wen", ci_wen, e_wen);
            chk("busy", busy, e_ren | e_wen);
            chk("grant_id", grant_id, e_id);
            chk("ci_flit", ci_flit, e_flit);
            n_ren  = 1'b0;
            n_id   = e_id;
            n_flit = e_flit;
            if (reset || e_ren || e_wen) begin
                chk("ready_quiet", req_ready, 0);
            end else if (req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", req_ready, 0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("grant_onehot", req_ready, 64'(1) << ex.id);
                    if (chk_gap && have_last) chk("grant_gap", cyc - last_gcyc, 3);
                    have_last = 1'b1;
                    last_gcyc = cyc;
                    n_ren  = 1'b1;
                    n_id   = 2'(ex.id);
                    n_flit = ex.flit;
                end
            end
            if (reset) begin
                e_ren = 1'b0; e_wen = 1'b0; e_id = '0; e_flit = '0;
            end else begin
                e_wen = e_ren; e_ren = n_ren; e_id = n_id; e_flit = n_flit;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic vc, input logic [31:0] f);
        req_valid[i]          = v;
        req_vc[i*VW +: VW]    = vc;
        req_flit[i*FW +: FW]  = f;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_vc    = '0;
        req_flit  = '0;
        vc_full   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        have_last = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    logic [31:0] fl[4];
    int          clr_cyc;

    initial begin
        fl[0] = 32'hA0A0_0001; fl[1] = 32'hB1B1_0002;
        fl[2] = 32'hC2C2_0003; fl[3] = 32'hD3D3_0004;
        clear_inputs();
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        mon_en = 1'b1;
        #1;
        reset = 1'b0;

        // 1: idle with no requests
        tick(10);

        // 2: single transfer timing
        exp_q.push_back('{id: 0, flit: 32'hDEADBEEF});
        set_req(0, 1'b1, 1'b1, 32'hDEADBEEF);
        wait_drain(10);
        req_valid = '0;
        tick(4);

        // 3: all requesters held on VC0 -> cyclic grants every 3 cycles
        do_reset();
        chk_gap = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{id: i, flit: fl[i]});
        exp_q.push_back('{id: 0, flit: fl[0]});
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, fl[i]);
        wait_drain(40);
        req_valid = '0;
        chk_gap = 1'b0;
        tick(4);

        // 4: full VC blocks req1 until released
        do_reset();
        exp_q.push_back('{id: 2, flit: fl[2]});
        vc_full = 2'b10;
        set_req(1, 1'b1, 1'b1, fl[1]);
        set_req(2, 1'b1, 1'b0, fl[2]);
        wait_drain(10);
        req_valid[2] = 1'b0;
        tick(6);
        exp_q.push_back('{id: 1, flit: fl[1]});
        vc_full = 2'b00;
        clr_cyc = cyc;
        wait_drain(10);
        chk("vc_release_latency_le1", (last_gcyc - clr_cyc) <= 1, 1);
        req_valid = '0;
        tick(4);

        // 5: VC goes full during READ, transfer still completes
        do_reset();
        exp_q.push_back('{id: 3, flit: fl[3]});
        set_req(3, 1'b1, 1'b0, fl[3]);
        wait_drain(10);
        vc_full = 2'b01;
        req_valid = '0;
        tick(4);
        vc_full = 2'b00;
        tick(1);

        // 6: reset during READ, pointer returns to 0
        do_reset();
        exp_q.push_back('{id: 2, flit: fl[2]});
        set_req(2, 1'b1, 1'b0, fl[2]);
        wait_drain(10);
        reset = 1'b1;
        req_valid = '0;
        tick(1);
        reset = 1'b0;
        exp_q.push_back('{id: 0, flit: fl[0]});
        exp_q.push_back('{id: 1, flit: fl[1]});
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, fl[i]);
        wait_drain(20);
        req_valid = '0;
        tick(4);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
